// File: rtl/arch_map_retire_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arch_map_retire_sched_pkg
// Description : Types and sizes shared by the retire scheduler, map table and
//               arch map.
// Revision    : 1.0 - initial release
// ============================================================================
package arch_map_retire_sched_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int PR_W          = 6;
    localparam int AR_W          = 5;

    // Alpha hardwired zero register
    localparam logic [AR_W-1:0] ZERO_REG_IDX = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_COPY  = 2'd2,
        ST_DONE  = 2'd3
    } RETIRE_SCHED_STATE_t;

    typedef struct packed {
        logic [AR_W-1:0] dest_idx;
        logic [PR_W-1:0] T_idx;
        logic [PR_W-1:0] Told_idx;
    } ROB_RETIRE_ENTRY_t;

    localparam int ENTRY_W = $bits(ROB_RETIRE_ENTRY_t);

endpackage
`default_nettype wire

// File: rtl/arch_map_retire_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : retire_fifo
// Description : Multi-push / single-pop in-order FIFO with count, head and
//               free-slot outputs. Push lanes must be contiguous from lane 0.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_fifo #(
    parameter int DEPTH  = 4,
    parameter int PUSH_W = 2,
    parameter int DATA_W = 17
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PUSH_W-1:0]          push_vld,
    input  logic [PUSH_W*DATA_W-1:0]   push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free_slots,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  w_push_cnt;
    logic [PTR_W-1:0]  w_slot;

    // Lane k lands k slots past the write pointer; pointers wrap naturally.
    always_comb begin
        mem_d      = mem_q;
        w_push_cnt = '0;
        w_slot     = wr_ptr_q;
        for (int i = 0; i < PUSH_W; i++) begin
            if (push_vld[i]) begin
                w_slot        = wr_ptr_q + w_push_cnt[PTR_W-1:0];
                mem_d[w_slot] = push_data[i*DATA_W +: DATA_W];
                w_push_cnt    = w_push_cnt + CNT_W'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + w_push_cnt[PTR_W-1:0];
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + w_push_cnt - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign empty      = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/arch_map_retire_sched.sv
`default_nettype none
// ============================================================================
// Module      : arch_map_retire_sched
// Description : Buffers retiring ROB entries and drains them one per cycle into
//               the arch map / free list; on flush, restores the map table from
//               the arch map. Option macro: ARCH_MAP_SKIP_ZERO_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module arch_map_retire_sched #(
    parameter int RETIRE_WIDTH  = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int NUM_ARCH_REGS = arch_map_retire_sched_pkg::NUM_ARCH_REGS,
    parameter int PR_W          = arch_map_retire_sched_pkg::PR_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [RETIRE_WIDTH-1:0]      rob_retire_valid,
    input  logic [RETIRE_WIDTH*5-1:0]    rob_dest_idx,
    input  logic [RETIRE_WIDTH*PR_W-1:0] rob_T_idx,
    input  logic [RETIRE_WIDTH*PR_W-1:0] rob_Told_idx,
    output logic                         rob_retire_ready,
    input  logic                         flush_req,
    output logic                         archmap_wr_en,
    output logic [4:0]                   archmap_dest_idx,
    output logic [PR_W-1:0]              archmap_T_idx,
    output logic                         freelist_free_en,
    output logic [PR_W-1:0]              freelist_Told_idx,
    output logic [4:0]                   arch_rd_idx,
    input  logic [PR_W-1:0]              arch_rd_T_idx,
    output logic                         maptable_wr_en,
    output logic [4:0]                   maptable_wr_idx,
    output logic [PR_W-1:0]              maptable_wr_T_idx,
    output logic                         flush_done
);

    import arch_map_retire_sched_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(NUM_ARCH_REGS);

    RETIRE_SCHED_STATE_t               state_q, state_d;
    logic [IDX_W-1:0]                  cnt_q, cnt_d;
    logic [RETIRE_WIDTH-1:0]           w_push_vld;
    logic [RETIRE_WIDTH*ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]                w_head_bits;
    ROB_RETIRE_ENTRY_t                 w_head;
    logic [CNT_W-1:0]                  w_count;
    logic [CNT_W-1:0]                  w_free;
    logic                              w_empty;
    logic                              w_ready;
    logic                              w_drain;
    logic                              w_arch_wr;

    for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
        ROB_RETIRE_ENTRY_t w_ent;
        assign w_ent.dest_idx = rob_dest_idx[gi*AR_W +: AR_W];
        assign w_ent.T_idx    = rob_T_idx[gi*PR_W +: PR_W];
        assign w_ent.Told_idx = rob_Told_idx[gi*PR_W +: PR_W];
        assign w_push_data[gi*ENTRY_W +: ENTRY_W] = w_ent;
    end

    assign w_push_vld = rob_retire_valid & {RETIRE_WIDTH{w_ready}};
    assign w_head     = w_head_bits;

    retire_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .PUSH_W (RETIRE_WIDTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_vld   (w_push_vld),
        .push_data  (w_push_data),
        .pop        (w_drain),
        .head_data  (w_head_bits),
        .count      (w_count),
        .free_slots (w_free),
        .empty      (w_empty)
    );

    // Reset is folded into ready so acceptance drops without waiting for an edge.
    assign w_ready = reset && en && (state_q == ST_RUN) && !flush_req &&
                     (w_free >= CNT_W'(RETIRE_WIDTH));
    assign w_drain = en && ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !w_empty;

`ifdef ARCH_MAP_SKIP_ZERO_REG_EN
    assign w_arch_wr = w_drain && (w_head.dest_idx != ZERO_REG_IDX);
`else
    assign w_arch_wr = w_drain;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    if (flush_req) state_d = ST_DRAIN;
                end
                // Leave on the edge that retires the last entry, so the first
                // COPY read already sees that final arch-map write.
                ST_DRAIN: begin
                    if (w_count == CNT_W'(w_drain)) begin
                        state_d = ST_COPY;
                        cnt_d   = '0;
                    end
                end
                ST_COPY: begin
                    if (cnt_q == IDX_W'(NUM_ARCH_REGS - 1)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
                ST_DONE: state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        rob_retire_ready  = w_ready;
        archmap_wr_en     = w_arch_wr;
        archmap_dest_idx  = w_drain ? w_head.dest_idx : '0;
        archmap_T_idx     = w_drain ? w_head.T_idx    : '0;
        freelist_free_en  = w_drain;
        freelist_Told_idx = w_drain ? w_head.Told_idx : '0;
        arch_rd_idx       = '0;
        maptable_wr_en    = 1'b0;
        maptable_wr_idx   = '0;
        maptable_wr_T_idx = '0;
        flush_done        = en && (state_q == ST_DONE);
        if (state_q == ST_COPY) begin
            arch_rd_idx     = cnt_q;
            maptable_wr_idx = cnt_q;
            if (en) begin
                maptable_wr_en    = 1'b1;
                maptable_wr_T_idx = arch_rd_T_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire
